// File: rtl/divider_issue_controller.sv
// Issue/retire controller between the execute stage and the M-extension Divider_Unit.
// Optional DIV_LAST_RESULT_CACHE_EN adds a last-result cache that bypasses repeated divisions.
`timescale 1ns/1ps
module divider_issue_controller #(
  parameter int TAG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIN_WAIT       = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6:0]           opcode,
  input  logic [6:0]           funct7,
  input  logic [2:0]           funct3,
  input  logic [7:0]           accuracy_level,
  input  logic [31:0]          rs1,
  input  logic [31:0]          rs2,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic [6:0]           div_opcode,
  output logic [6:0]           div_funct7,
  output logic [2:0]           div_funct3,
  output logic [7:0]           div_accuracy_level,
  output logic [31:0]          div_rs1,
  output logic [31:0]          div_rs2,
  input  logic                 div_unit_busy,
  input  logic [31:0]          div_output,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_err,
  output logic                 stall
);

  localparam int         CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] F7_M = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     f3_q, f3_d;
  logic [7:0]     acc_q, acc_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    data_d;
  logic [TAG_WIDTH-1:0] tag_d;
  logic           err_d;

  logic           legal_s, zero_s, ovf_s, hit_s, done_s, issuing_s;
  logic [CW-1:0]  cnt_inc_s;
  logic [31:0]    hit_data_s;

  assign legal_s   = (opcode == OP_R) && (funct7 == F7_M) && funct3[2];
  assign zero_s    = (rs2 == 32'h0000_0000);
  assign ovf_s     = !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};
  // Busy low is only trusted once MIN_WAIT cycles have elapsed, giving the divider time to raise it.
  assign done_s    = (cnt_inc_s >= CW'(MIN_WAIT)) && !div_unit_busy;
  assign issuing_s = (state_d == S_ISSUE) || (state_d == S_WAIT);

`ifdef DIV_LAST_RESULT_CACHE_EN
  logic        cv_q;
  logic [2:0]  cf3_q;
  logic [31:0] ca_q, cb_q, cd_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cv_q  <= 1'b0;
      cf3_q <= 3'b000;
      ca_q  <= 32'h0;
      cb_q  <= 32'h0;
      cd_q  <= 32'h0;
    end else if ((state_q == S_WAIT) && done_s) begin
      cv_q  <= 1'b1;
      cf3_q <= f3_q;
      ca_q  <= a_q;
      cb_q  <= b_q;
      cd_q  <= div_output;
    end
  end

  assign hit_s      = cv_q && (cf3_q == funct3) && (ca_q == rs1) && (cb_q == rs2);
  assign hit_data_s = cd_q;
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'h0;
`endif

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    data_d  = resp_data;
    tag_d   = resp_tag;
    err_d   = resp_err;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d  = funct3;
          acc_d = accuracy_level;
          a_d   = rs1;
          b_d   = rs2;
          tag_d = req_tag;
          err_d = 1'b0;
          if (!legal_s) begin
            state_d = S_RESP;
            data_d  = 32'h0;
            err_d   = 1'b1;
          end else if (zero_s) begin
            state_d = S_RESP;
            data_d  = funct3[1] ? rs1 : 32'hFFFF_FFFF;
          end else if (ovf_s) begin
            state_d = S_RESP;
            data_d  = funct3[1] ? 32'h0 : 32'h8000_0000;
          end else if (hit_s) begin
            state_d = S_RESP;
            data_d  = hit_data_s;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = {CW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc_s;
        if (done_s) begin
          data_d  = div_output;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_inc_s >= CW'(TIMEOUT_CYCLES)) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      f3_q    <= 3'b000;
      acc_q   <= 8'h00;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered from next-state so they line up with state_q every cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      req_ready          <= 1'b1;
      stall              <= 1'b0;
      resp_valid         <= 1'b0;
      resp_data          <= 32'h0;
      resp_tag           <= {TAG_WIDTH{1'b0}};
      resp_err           <= 1'b0;
      div_opcode         <= 7'b0000000;
      div_funct7         <= 7'b0000000;
      div_funct3         <= 3'b000;
      div_accuracy_level <= 8'h00;
      div_rs1            <= 32'h0;
      div_rs2            <= 32'h0;
    end else begin
      req_ready          <= (state_d == S_IDLE);
      stall              <= (state_d != S_IDLE);
      resp_valid         <= (state_d == S_RESP);
      resp_data          <= data_d;
      resp_tag           <= tag_d;
      resp_err           <= err_d;
      div_opcode         <= issuing_s ? OP_R : 7'b0000000;
      div_funct7         <= issuing_s ? F7_M : 7'b0000000;
      div_funct3         <= issuing_s ? f3_d : 3'b000;
      div_accuracy_level <= issuing_s ? acc_d : 8'h00;
      div_rs1            <= issuing_s ? a_d : 32'h0;
      div_rs2            <= issuing_s ? b_d : 32'h0;
    end
  end

endmodule

// File: tb/tb_divider_issue_controller.sv
// Randomized self-checking bench for divider_issue_controller with a transaction-level reference
// model and a behavioural divider stub whose busy latency is chosen per request.
`timescale 1ns/1ps
module tb_divider_issue_controller;
  localparam int TW = 5;
  localparam int TO = 12;
  localparam int MW = 2;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] F7M = 7'b0000001;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [6:0]    opcode = 7'h0, funct7 = 7'h0;
  logic [2:0]    funct3 = 3'h0;
  logic [7:0]    accuracy_level = 8'h0;
  logic [31:0]   rs1 = 32'h0, rs2 = 32'h0;
  logic [TW-1:0] req_tag = '0;
  logic [6:0]    div_opcode, div_funct7;
  logic [2:0]    div_funct3;
  logic [7:0]    div_accuracy_level;
  logic [31:0]   div_rs1, div_rs2;
  logic          div_unit_busy = 1'b0;
  logic [31:0]   div_output = 32'h0;
  logic          resp_valid, resp_ready = 1'b0;
  logic [31:0]   resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_err, stall;

  always #5 CLK = ~CLK;

  divider_issue_controller #(.TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO), .MIN_WAIT(MW)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct7(funct7), .funct3(funct3), .accuracy_level(accuracy_level),
    .rs1(rs1), .rs2(rs2), .req_tag(req_tag),
    .div_opcode(div_opcode), .div_funct7(div_funct7), .div_funct3(div_funct3),
    .div_accuracy_level(div_accuracy_level), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_unit_busy(div_unit_busy), .div_output(div_output),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .stall(stall)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_sent = 0;
  int n_done = 0;
  int start_c = 0, resp_c = 0, iss_lo = 0, iss_hi = 0;
  bit e_issue = 1'b0;
  logic [31:0] e_data = 32'h0, e_a = 32'h0, e_b = 32'h0;
  logic [TW-1:0] e_tag = '0;
  logic e_err = 1'b0;
  logic [2:0] e_f3 = 3'h0;
  logic [7:0] e_acc = 8'h0;
  int lat_cfg = 1;
  logic [31:0] last_data = 32'h0;
  logic [TW-1:0] last_tag = '0;
  logic last_err = 1'b0;
`ifdef DIV_LAST_RESULT_CACHE_EN
  bit m_cv = 1'b0;
  logic [2:0] m_cf3 = 3'h0;
  logic [31:0] m_ca = 32'h0, m_cb = 32'h0, m_cd = 32'h0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // RISC-V division semantics for the non-special cases (also used by the divider stub).
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (y == 32'h0) r = 32'h0;
    else if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = f[1] ? 32'h0 : x;
    else begin
      case (f)
        3'd4:    r = $signed(x) / $signed(y);
        3'd5:    r = x / y;
        3'd6:    r = $signed(x) % $signed(y);
        default: r = x % y;
      endcase
    end
    return r;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Divider stub: raises busy when it sees an instruction, drops it lat_cfg cycles later.
  initial begin : div_model
    bit active;
    int rem;
    active = 1'b0;
    rem = 0;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        active = 1'b0;
        div_unit_busy = 1'b0;
      end else if (!active && div_opcode == OPR) begin
        active = 1'b1;
        rem = lat_cfg;
        div_unit_busy = (rem > 0);
        div_output = ref_op(div_funct3, div_rs1, div_rs2);
      end else if (active) begin
        if (div_opcode != OPR) begin
          active = 1'b0;
          div_unit_busy = 1'b0;
          div_output = $urandom;
        end else begin
          if (rem > 0) rem--;
          div_unit_busy = (rem > 0);
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the current transaction expectation.
  initial forever begin
    @(negedge CLK);
    if (reset) begin
      if (n_sent == n_done || cyc < start_c) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_div_opcode", 32'(div_opcode), 32'd0);
      end else if (cyc < resp_c) begin
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_resp_valid", 32'(resp_valid), 32'd0);
        if (e_issue && cyc >= iss_lo && cyc <= iss_hi) begin
          chk("iss_opcode", 32'(div_opcode), 32'(OPR));
          chk("iss_funct7", 32'(div_funct7), 32'(F7M));
          chk("iss_funct3", 32'(div_funct3), 32'(e_f3));
          chk("iss_acc", 32'(div_accuracy_level), 32'(e_acc));
          chk("iss_rs1", div_rs1, e_a);
          chk("iss_rs2", div_rs2, e_b);
        end else begin
          chk("noiss_opcode", 32'(div_opcode), 32'd0);
          chk("noiss_funct7", 32'(div_funct7), 32'd0);
        end
      end else begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_stall", 32'(stall), 32'd1);
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        chk("resp_data", resp_data, e_data);
        chk("resp_tag", 32'(resp_tag), 32'(e_tag));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_div_opcode", 32'(div_opcode), 32'd0);
        if (resp_ready) begin
          last_data = resp_data;
          last_tag = resp_tag;
          last_err = resp_err;
          n_done++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_tag"}, 32'(resp_tag), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_div_opcode"}, 32'(div_opcode), 32'd0);
    chk({tag, "_div_funct7"}, 32'(div_funct7), 32'd0);
    chk({tag, "_div_funct3"}, 32'(div_funct3), 32'd0);
    chk({tag, "_div_acc"}, 32'(div_accuracy_level), 32'd0);
    chk({tag, "_div_rs1"}, div_rs1, 32'd0);
    chk({tag, "_div_rs2"}, div_rs2, 32'd0);
  endtask

  // One request/response transaction; called at posedge+2 with the DUT idle.
  // rr_mode: 0 random resp_ready, 1 always ready, 2 withhold ready for 5 response cycles.
  task automatic tx(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tg,
                    input int lat, input int rr_mode, input int kill_at);
    bit legal, fast, er, killed;
    int k, keff;
    logic [31:0] d;
    legal = (opc == OPR) && (f7 == F7M) && f3[2];
    fast = 1'b1; er = 1'b0; d = 32'h0; keff = 0; killed = 1'b0;
    if (!legal) er = 1'b1;
    else if (b == 32'h0) d = f3[1] ? a : 32'hFFFF_FFFF;
    else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) d = f3[1] ? 32'h0 : 32'h8000_0000;
`ifdef DIV_LAST_RESULT_CACHE_EN
    else if (m_cv && m_cf3 == f3 && m_ca == a && m_cb == b) d = m_cd;
`endif
    else begin
      fast = 1'b0;
      k = (lat > MW) ? lat : MW;
      if (k > TO) begin
        keff = TO; er = 1'b1; d = 32'h0;
      end else begin
        keff = k; d = ref_op(f3, a, b);
`ifdef DIV_LAST_RESULT_CACHE_EN
        m_cv = 1'b1; m_cf3 = f3; m_ca = a; m_cb = b; m_cd = d;
`endif
      end
    end
    start_c = cyc + 1;
    e_issue = !fast;
    iss_lo = start_c;
    iss_hi = start_c + keff;
    resp_c = fast ? start_c : start_c + 1 + keff;
    e_data = d; e_tag = tg; e_err = er; e_f3 = f3; e_a = a; e_b = b;
    e_acc = 8'($urandom());
    lat_cfg = lat;
    n_sent++;
    req_valid = 1'b1; opcode = opc; funct7 = f7; funct3 = f3;
    accuracy_level = e_acc; rs1 = a; rs2 = b; req_tag = tg;
    resp_ready = (rr_mode == 1);
    @(posedge CLK); #2;
    req_valid = 1'b0; opcode = 7'($urandom()); rs1 = $urandom; rs2 = $urandom;
    funct3 = 3'($urandom()); accuracy_level = 8'($urandom());
    for (int i = 0; i < 200; i++) begin
      if (n_sent == n_done) break;
      if (kill_at > 0 && cyc == start_c + kill_at) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        n_sent = n_done;
`ifdef DIV_LAST_RESULT_CACHE_EN
        m_cv = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #2;
        reset = 1'b1;
        killed = 1'b1;
        break;
      end
      case (rr_mode)
        0:       resp_ready = ($urandom_range(0, 2) != 0);
        1:       resp_ready = 1'b1;
        default: resp_ready = (cyc >= resp_c + 5);
      endcase
      @(posedge CLK); #2;
    end
    if (!killed && n_sent != n_done) begin
      checks++; failures++;
      $display("FAIL handshake_timeout actual=no_handshake expected=handshake cycle=%0d", cyc);
      n_sent = n_done;
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] opc, f7;
    logic [2:0] f3, pf3;
    logic [31:0] a, b, pa, pb;
    int sel;
    #1 reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    #1;
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    #2;

    tx(OPR, F7M, 3'd5, 32'd400, 32'd20, 5'd3, 1, 1, 0);
    chk("lit_divu_data", last_data, 32'd20);
    chk("lit_divu_tag", 32'(last_tag), 32'd3);
    chk("lit_divu_err", 32'(last_err), 32'd0);
    chk("pin_divu_latency", 32'(resp_c - start_c + 1), 32'(2 + MW));

    tx(OPR, F7M, 3'd5, 32'd7, 32'd0, 5'd4, 1, 1, 0);
    chk("lit_divu_zero", last_data, 32'hFFFF_FFFF);
    tx(OPR, F7M, 3'd7, 32'd7, 32'd0, 5'd5, 1, 1, 0);
    chk("lit_remu_zero", last_data, 32'd7);
    tx(OPR, F7M, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 1, 0);
    chk("lit_div_ovf", last_data, 32'h8000_0000);
    tx(OPR, F7M, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 1, 0);
    chk("lit_rem_ovf", last_data, 32'h0);
    tx(OPR, 7'b0000000, 3'd0, 32'd9, 32'd3, 5'd8, 1, 1, 0);
    chk("lit_illegal_err", 32'(last_err), 32'd1);
    chk("lit_illegal_data", last_data, 32'd0);
    tx(OPR, F7M, 3'd5, 32'd99, 32'd3, 5'd9, 1000, 1, 0);
    chk("lit_timeout_err", 32'(last_err), 32'd1);
    chk("pin_timeout_latency", 32'(resp_c - start_c + 1), 32'(2 + TO));
    tx(OPR, F7M, 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd10, TO, 1, 0);
    chk("lit_tie_completes", last_data, 32'hFFFF_FFF2);
    chk("lit_tie_err", 32'(last_err), 32'd0);
    tx(OPR, F7M, 3'd7, 32'd500, 32'd20, 5'd11, 1, 2, 0);
    chk("lit_remu_hold", last_data, 32'd0);
    chk("lit_remu_hold_tag", 32'(last_tag), 32'd11);
    tx(OPR, F7M, 3'd5, 32'd1000, 32'd3, 5'd12, 10, 1, 3);
    repeat (6) @(posedge CLK);
    #2;
`ifdef DIV_LAST_RESULT_CACHE_EN
    tx(OPR, F7M, 3'd5, 32'd400, 32'd20, 5'd13, 1, 1, 0);
    tx(OPR, F7M, 3'd5, 32'd400, 32'd20, 5'd14, 1, 1, 0);
    chk("pin_cache_latency", 32'(resp_c - start_c + 1), 32'd1);
    chk("lit_cache_data", last_data, 32'd20);
`endif

    pf3 = 3'd5; pa = 32'd400; pb = 32'd20;
    for (int t = 0; t < 160; t++) begin
      sel = $urandom_range(0, 9);
      opc = OPR; f7 = F7M;
      f3 = 3'($urandom_range(4, 7));
      a = $urandom; b = $urandom;
      case (sel)
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: if ($urandom_range(0, 1) == 0) f3 = 3'($urandom_range(0, 3)); else opc = 7'b0010011;
        3: begin f3 = pf3; a = pa; b = pb; end
        4: b = 32'($urandom_range(1, 15));
        5: f7 = 7'($urandom_range(2, 127));
        default: ;
      endcase
      tx(opc, f7, f3, a, b, TW'($urandom()), $urandom_range(0, TO + 2), 0, 0);
      if (sel != 2 && sel != 5) begin pf3 = f3; pa = a; pb = b; end
    end

    repeat (3) @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
